// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word width, instruction-cache geometry
// defaults and the instruction-cache refill FSM states.
package cpu_pkg;
  localparam int WORD                  = 32;
  localparam int ICACHE_SETS_DEF       = 64;
  localparam int ICACHE_LINE_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    REFILL,
    RESP
  } icache_state_e;
endpackage

// File: rtl/icache_ram.sv
// Simple dual-port array (one write port, one read port) with registered read
// data; used for both the tag store and the data store of the instruction cache.
module icache_ram
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD,
  parameter int DEPTH = ICACHE_SETS_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto plain SRAM; line validity lives in flops elsewhere.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: one-cycle hit path, blocking line refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_dm
  import cpu_pkg::*;
#(
  parameter int ICACHE_SETS       = ICACHE_SETS_DEF,
  parameter int ICACHE_LINE_WORDS = ICACHE_LINE_WORDS_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [WORD-1:0] req_pc,
  input  logic            flush,
  output logic            resp_valid,
  output logic [WORD-1:0] resp_pc,
  output logic [WORD-1:0] resp_inst,
  output logic            stall,
  output logic            mem_rd_req,
  output logic [WORD-1:0] mem_rd_addr,
  input  logic            mem_rd_ready,
  input  logic            mem_rd_valid,
  input  logic [WORD-1:0] mem_rd_data,
  input  logic            mem_rd_last
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
`endif
);
  localparam int OFF_W = $clog2(ICACHE_LINE_WORDS);
  localparam int IDX_W = $clog2(ICACHE_SETS);
  localparam int LO    = OFF_W + 2;
  localparam int TAG_W = WORD - IDX_W - LO;

  icache_state_e r_state, w_next;

  logic [ICACHE_SETS-1:0] r_valid;
  logic                   r_lookup;      // request accepted last cycle, tag compare pending
  logic                   r_lookup_vld;  // valid bit as seen when the request was accepted
  logic [WORD-1:0]        r_pc;
  logic [OFF_W-1:0]       r_beat;
  logic [WORD-1:0]        r_miss_word;
  logic                   r_fill_kill;   // flush hit the line being refilled

  logic [IDX_W-1:0] w_req_idx, w_pc_idx;
  logic [OFF_W-1:0] w_req_off, w_pc_off;
  logic [TAG_W-1:0] w_pc_tag, w_tag_rd;
  logic [WORD-1:0]  w_data_rd;
  logic             w_hit, w_miss, w_accept, w_beat;

  assign w_req_idx = req_pc[LO +: IDX_W];
  assign w_req_off = req_pc[2 +: OFF_W];
  assign w_pc_idx  = r_pc[LO +: IDX_W];
  assign w_pc_off  = r_pc[2 +: OFF_W];
  assign w_pc_tag  = r_pc[WORD-1 -: TAG_W];

  // Validity is sampled at acceptance so a same-cycle flush cannot cancel a hit.
  assign w_hit    = r_lookup && r_lookup_vld && (w_tag_rd == w_pc_tag);
  assign w_miss   = r_lookup && !w_hit;
  assign w_accept = (r_state == IDLE) && req_valid && !w_miss;
  assign w_beat   = (r_state == REFILL) && mem_rd_valid;

  icache_ram #(.WIDTH(TAG_W), .DEPTH(ICACHE_SETS)) u_tag_ram (
    .clk     (clk),
    .i_we    (r_state == RESP),
    .i_waddr (w_pc_idx),
    .i_wdata (w_pc_tag),
    .i_raddr (w_req_idx),
    .o_rdata (w_tag_rd)
  );

  icache_ram #(.WIDTH(WORD), .DEPTH(ICACHE_SETS * ICACHE_LINE_WORDS)) u_data_ram (
    .clk     (clk),
    .i_we    (w_beat),
    .i_waddr ({w_pc_idx, r_beat}),
    .i_wdata (mem_rd_data),
    .i_raddr ({w_req_idx, w_req_off}),
    .o_rdata (w_data_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_miss) w_next = MISS_REQ;
      MISS_REQ: if (mem_rd_ready) w_next = REFILL;
      REFILL:   if (mem_rd_valid && mem_rd_last) w_next = RESP;
      RESP:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no branch can leave a latch behind.
  always_comb begin
    resp_valid  = 1'b0;
    resp_pc     = '0;
    resp_inst   = '0;
    stall       = 1'b0;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    unique case (r_state)
      IDLE: begin
        stall = w_miss;
        if (w_hit) begin
          resp_valid = 1'b1;
          resp_pc    = r_pc;
          resp_inst  = w_data_rd;
        end
      end
      MISS_REQ: begin
        stall       = 1'b1;
        mem_rd_req  = 1'b1;
        mem_rd_addr = {r_pc[WORD-1:LO], {LO{1'b0}}};
      end
      REFILL: stall = 1'b1;
      RESP: begin
        resp_valid = 1'b1;
        resp_pc    = r_pc;
        resp_inst  = r_miss_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lookup     <= 1'b0;
      r_lookup_vld <= 1'b0;
      r_pc         <= '0;
      r_beat       <= '0;
      r_miss_word  <= '0;
      r_fill_kill  <= 1'b0;
    end else begin
      r_lookup <= w_accept;
      if (w_accept) begin
        r_pc         <= req_pc;
        r_lookup_vld <= r_valid[w_req_idx];
      end
      if (w_miss) begin
        r_beat      <= '0;
        r_fill_kill <= flush;
      end else if (flush && (r_state inside {MISS_REQ, REFILL})) begin
        r_fill_kill <= 1'b1;
      end
      if (w_beat) begin
        r_beat <= r_beat + 1'b1;
        if (r_beat == w_pc_off) r_miss_word <= mem_rd_data;
      end
    end
  end

  // Flush wins over the RESP line install so a flushed refill stays invalid.
  always_ff @(posedge clk) begin
    if (rst || flush)                         r_valid           <= '0;
    else if (r_state == RESP && !r_fill_kill) r_valid[w_pc_idx] <= 1'b1;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`else
  // Default build carries no statistics logic.
`endif
endmodule

// File: doc/icache_dm.md
ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 Parameter ICACHE_SETS, default 64, number of direct-mapped lines (power of two).
REQ-002 Parameter ICACHE_LINE_WORDS, default 4, 32-bit words per line (power of two).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  IF0 fetch request valid.
REQ-006 req_pc  input  32  IF0 fetch address; bits [1:0] ignored.
REQ-007 flush  input  1  invalidate all lines.
REQ-008 resp_valid  output  1  IF1 instruction valid.
REQ-009 resp_pc  output  32  PC of the returned instruction.
REQ-010 resp_inst  output  32  returned instruction word.
REQ-011 stall  output  1  miss in progress; IF0 holds req_pc/req_valid stable.
REQ-012 mem_rd_req  output  1  refill burst request.
REQ-013 mem_rd_addr  output  32  line-aligned burst base address.
REQ-014 mem_rd_ready  input  1  memory accepts request (handshake: req & ready).
REQ-015 mem_rd_valid  input  1  refill data beat valid.
REQ-016 mem_rd_data  input  32  refill data beat.
REQ-017 mem_rd_last  input  1  final beat of burst.

Function
REQ-018 Address split (defaults): offset = pc[3:2], index = pc[9:4], tag = pc[31:10]; widths SHALL derive from parameters.
REQ-019 Hit: request accepted in cycle N (state IDLE, req_valid=1, tag match, line valid) SHALL give resp_valid=1, resp_pc=req_pc, resp_inst=word in cycle N+1; stall stays 0.
REQ-020 req_valid=0 in IDLE SHALL give resp_valid=0 in the next cycle.
REQ-021 FSM states: IDLE, MISS_REQ, REFILL, RESP.
REQ-022 IDLE -> MISS_REQ on accepted miss; stall SHALL assert the following cycle and stay high until RESP.
REQ-023 MISS_REQ: mem_rd_req=1, mem_rd_addr = {pc[31:4], 4'b0}; -> REFILL on mem_rd_req & mem_rd_ready.
REQ-024 REFILL: each mem_rd_valid beat fills word 0,1,2,3 in order; on beat with mem_rd_last -> RESP; beats outside REFILL SHALL be ignored.
REQ-025 RESP (one cycle): write tag/data, set valid bit, drive resp_valid=1 with missed word and PC, stall=0; -> IDLE.
REQ-026 Requests while stall=1 SHALL not be re-evaluated; the captured PC is served.
REQ-027 flush in any state SHALL clear all valid bits next cycle; flush during MISS_REQ/REFILL SHALL still return the refilled word in RESP but leave that line invalid.
REQ-028 flush and hit in the same cycle: response SHALL still be delivered; invalidation takes effect after.
REQ-029 resp_valid SHALL never be high for two consecutive cycles for the same miss.

Reset
REQ-030 rst SHALL force IDLE, clear all valid bits, resp_valid=0, resp_pc=0, resp_inst=0, stall=0, mem_rd_req=0, mem_rd_addr=0.
REQ-031 rst mid-refill SHALL abandon the burst; later data beats ignored; no line marked valid.
REQ-032 Tag/data arrays need no reset.

Configuration
REQ-033 Macro ICACHE_STATS_EN defined: outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0, incremented once per hit/miss, wrapping at 2^32.
REQ-034 Macro undefined: counters and ports absent; behaviour otherwise identical.

Structure
REQ-035 Shared package cpu_pkg holds WORD width, ICACHE_SETS, ICACHE_LINE_WORDS defaults and the FSM state enum.
REQ-036 One sub-module icache_ram: parameterised data/tag array, one read port, one write port, read data registered.
REQ-037 Valid bits SHALL be flops in icache_dm (single-cycle flush).

Verification
REQ-038 Reset then req_pc=0x1C000000 valid -> miss, stall=1, mem_rd_addr=0x1C000000; beats 0xA0..0xA3 -> RESP resp_inst=0xA0, resp_pc=0x1C000000.
REQ-039 After REQ-038, req_pc=0x1C000008 -> next cycle resp_valid=1, resp_inst=0xA2, stall=0.
REQ-040 req_pc=0x1C000400 (same index, new tag) -> miss, refill, then 0x1C000000 misses again.
REQ-041 flush asserted during REFILL beat 2 -> word returned once, following re-fetch of same PC misses.
REQ-042 rst during REFILL beat 1, then stray mem_rd_valid beats -> no resp_valid, stall=0, next fetch of same PC misses.
REQ-043 ICACHE_STATS_EN build: 1 miss + 3 hits -> hit_cnt=3, miss_cnt=1.
